// File: rtl/regfile_resp_pkg.sv
// regfile_resp_pkg: shared register-file constants and the IDLE/ACK port state encoding.
package regfile_resp_pkg;
   localparam int IDX_W    = 5;
   localparam int NREG_DEF = 32;
   typedef enum logic {ST_IDLE = 1'b0, ST_ACK = 1'b1} port_st_e;
endpackage

// File: rtl/regfile_resp_port_fsm.sv
// regfile_port_fsm: IDLE/ACK request handshake; o_fire marks the accepting edge, o_ack is the registered pulse.
module regfile_port_fsm
   import regfile_resp_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_req,
   output logic o_fire,
   output logic o_ack
);
   port_st_e r_st;
   assign o_fire = (r_st == ST_IDLE) && i_req;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_st  <= ST_IDLE;
         o_ack <= 1'b0;
      end else if (r_st == ST_IDLE) begin
         r_st  <= i_req ? ST_ACK : ST_IDLE;
         o_ack <= i_req;
      end else begin
         r_st  <= ST_IDLE;
         o_ack <= 1'b0;
      end
   end
endmodule

// File: rtl/regfile_resp.sv
// regfile_resp: register file with independent read/write IDLE/ACK handshakes.
// REGFILE_WR_BYPASS_EN forwards a same-edge write to a same-index read.
module regfile_resp
   import regfile_resp_pkg::*;
#(
   parameter int REG_SZ = 32,
   parameter int NREG   = NREG_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              reg_re,
   input  logic [IDX_W-1:0]  reg_idx,
   output logic              reg_rack,
   output logic [REG_SZ-1:0] reg_dout,
   input  logic              wb_we,
   input  logic [IDX_W-1:0]  wb_idx,
   input  logic [REG_SZ-1:0] wb_val,
   output logic              wb_wack
);
   logic [REG_SZ-1:0] r_mem [NREG];
   logic              w_rfire;
   logic              w_wfire;
   logic [REG_SZ-1:0] w_rd_mem;
   logic [REG_SZ-1:0] w_rd_val;

   regfile_port_fsm u_rd (.clk(clk), .rst(rst), .i_req(reg_re), .o_fire(w_rfire), .o_ack(reg_rack));
   regfile_port_fsm u_wr (.clk(clk), .rst(rst), .i_req(wb_we),  .o_fire(w_wfire), .o_ack(wb_wack));

   // x0 and out-of-range indices always read as zero
   assign w_rd_mem = (reg_idx != '0 && 32'(reg_idx) < NREG) ? r_mem[reg_idx] : '0;

`ifdef REGFILE_WR_BYPASS_EN
   assign w_rd_val = (w_wfire && wb_idx == reg_idx && reg_idx != '0) ? wb_val : w_rd_mem;
`else
   assign w_rd_val = w_rd_mem;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
      end else if (w_wfire && wb_idx != '0 && 32'(wb_idx) < NREG) begin
         r_mem[wb_idx] <= wb_val;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) reg_dout <= '0;
      else if (w_rfire) reg_dout <= w_rd_val;
   end
endmodule
